// File: rtl/stream_bridge_pkg.sv
// stream_bridge_pkg: shared definitions for the stream port bridge.
//   - bridge_state_e : bridge FSM state encoding
//   - Def*           : default parameter values for the bridge top
//   - byte_addr()    : word address -> byte address relative to a base
package stream_bridge_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStep,
        StSample,
        StServe,
        StWaitRd,
        StWaitWr,
        StFinish
    } bridge_state_e;

    localparam int unsigned DefAddrWid  = 16;
    localparam int unsigned DefDataWid  = 32;
    localparam int unsigned DefNumPorts = 2;
    localparam int unsigned DefHitCache = 1;
    localparam int unsigned DefTimeout  = 1024;

    // Accelerator addresses are 32-bit word indices; the host bus is byte addressed.
    function automatic logic [63:0] byte_addr(input logic [63:0] base, input logic [63:0] word);
        return base + (word << 2);
    endfunction

endpackage

// File: rtl/port_read_cache.sv
// port_read_cache: single-entry {valid, addr, data} record of the last external read of one
// accelerator port.
//   clk, reset            : clock, asynchronous active-low reset
//   clear                 : synchronous flush of the entry
//   fill_en/addr/data     : record a completed external read
//   inv_en/inv_addr       : served write; drops the entry if the address matches
//   lookup_addr           : address of the read being served on this port
//   hit, hit_data         : entry valid and matching lookup_addr, with its data
module port_read_cache
    import stream_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WID = DefAddrWid,
    parameter int unsigned DATA_WID = DefDataWid
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                fill_en,
    input  logic [ADDR_WID-1:0] fill_addr,
    input  logic [DATA_WID-1:0] fill_data,
    input  logic                inv_en,
    input  logic [ADDR_WID-1:0] inv_addr,
    input  logic [ADDR_WID-1:0] lookup_addr,
    output logic                hit,
    output logic [DATA_WID-1:0] hit_data
);

    logic                valid_q, valid_d;
    logic [ADDR_WID-1:0] addr_q, addr_d;
    logic [DATA_WID-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (fill_en) begin
            valid_d = 1'b1;
            addr_d  = fill_addr;
            data_d  = fill_data;
        end else if (inv_en && (addr_q == inv_addr)) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign hit      = valid_q && (addr_q == lookup_addr);
    assign hit_data = data_q;

endmodule

// File: rtl/stream_port_bridge.sv
// stream_port_bridge: single-steps an accelerator and turns its memory-port accesses into host
// read/write requests, one at a time, lowest port first.
//   clk, reset                 : clock, asynchronous active-low reset
//   start                      : level, run request; drop it to leave FINISH
//   read_base/write_base       : byte base addresses of the host buffers
//   xfer_size                  : copied to rd_size / wr_size
//   acc_addr/ce/we/d, acc_q    : packed accelerator memory ports
//   acc_step, acc_start        : accelerator clock enable pulse, ap_start
//   acc_done                   : accelerator ap_done
//   rd_*/wr_*                  : host request pulses, address, size, data and ready
//   done, error                : sticky completion / host timeout flags
//   access_count, cycle_count  : host requests issued, acc_step pulses issued
module stream_port_bridge
    import stream_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WID  = DefAddrWid,
    parameter int unsigned DATA_WID  = DefDataWid,
    parameter int unsigned NUM_PORTS = DefNumPorts,
    parameter int unsigned HIT_CACHE = DefHitCache,
    parameter int unsigned TIMEOUT   = DefTimeout
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [63:0]                   read_base,
    input  logic [63:0]                   write_base,
    input  logic [63:0]                   xfer_size,
    input  logic [NUM_PORTS*ADDR_WID-1:0] acc_addr,
    input  logic [NUM_PORTS-1:0]          acc_ce,
    input  logic [NUM_PORTS-1:0]          acc_we,
    input  logic [NUM_PORTS*DATA_WID-1:0] acc_d,
    output logic [NUM_PORTS*DATA_WID-1:0] acc_q,
    output logic                          acc_step,
    output logic                          acc_start,
    input  logic                          acc_done,
    output logic                          rd_req,
    output logic                          wr_req,
    output logic [63:0]                   rd_addr,
    output logic [63:0]                   wr_addr,
    output logic [63:0]                   rd_size,
    output logic [63:0]                   wr_size,
    output logic [DATA_WID-1:0]           wr_data,
    input  logic                          rd_ready,
    input  logic                          wr_ready,
    input  logic [DATA_WID-1:0]           rd_data,
    output logic                          done,
    output logic                          error,
    output logic [63:0]                   access_count,
    output logic [63:0]                   cycle_count
);

    localparam int unsigned PortIdxW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    bridge_state_e state_q, state_d;

    logic [NUM_PORTS-1:0]          pend_q, pend_d;
    logic [NUM_PORTS-1:0]          pend_we_q, pend_we_d;
    logic [NUM_PORTS*ADDR_WID-1:0] pend_addr_q, pend_addr_d;
    logic [NUM_PORTS*DATA_WID-1:0] pend_wdata_q, pend_wdata_d;
    logic [NUM_PORTS*DATA_WID-1:0] acc_q_q, acc_q_d;
    logic [PortIdxW-1:0]           cur_q, cur_d;
    logic [31:0]                   timer_q, timer_d;
    logic                          rd_req_q, rd_req_d;
    logic                          wr_req_q, wr_req_d;
    logic [63:0]                   rd_addr_q, rd_addr_d;
    logic [63:0]                   wr_addr_q, wr_addr_d;
    logic [63:0]                   rd_size_q, rd_size_d;
    logic [63:0]                   wr_size_q, wr_size_d;
    logic [DATA_WID-1:0]           wr_data_q, wr_data_d;
    logic                          done_q, done_d;
    logic                          error_q, error_d;
    logic [63:0]                   access_count_q, access_count_d;
    logic [63:0]                   cycle_count_q, cycle_count_d;

    // Lowest-index pending port and its latched access.
    logic                sel_valid;
    logic [PortIdxW-1:0] sel_idx;
    logic                sel_we;
    logic                sel_hit;
    logic [ADDR_WID-1:0] sel_addr;
    logic [DATA_WID-1:0] sel_wdata;
    logic                timed_out;

    logic                cache_clear;
    logic                cache_fill;
    logic                cache_inv;
    logic [NUM_PORTS-1:0] cache_hit;
    logic [DATA_WID-1:0] cache_data [NUM_PORTS];

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cache
        logic raw_hit;

        port_read_cache #(
            .ADDR_WID (ADDR_WID),
            .DATA_WID (DATA_WID)
        ) u_cache (
            .clk         (clk),
            .reset       (reset),
            .clear       (cache_clear),
            .fill_en     (cache_fill && (cur_q == PortIdxW'(i))),
            .fill_addr   (pend_addr_q[i*ADDR_WID +: ADDR_WID]),
            .fill_data   (rd_data),
            .inv_en      (cache_inv),
            .inv_addr    (sel_addr),
            .lookup_addr (pend_addr_q[i*ADDR_WID +: ADDR_WID]),
            .hit         (raw_hit),
            .hit_data    (cache_data[i])
        );

        assign cache_hit[i] = (HIT_CACHE != 0) && raw_hit;
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_valid = 1'b1;
                sel_idx   = PortIdxW'(i);
            end
        end
    end

    assign sel_we    = pend_we_q[sel_idx];
    assign sel_hit   = cache_hit[sel_idx];
    assign sel_addr  = pend_addr_q[sel_idx*ADDR_WID +: ADDR_WID];
    assign sel_wdata = pend_wdata_q[sel_idx*DATA_WID +: DATA_WID];
    // Entered the wait with timer 0, so this fires on the (TIMEOUT+1)-th cycle without ready.
    assign timed_out = (timer_q >= TIMEOUT);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StStep;
            StStep:   state_d = StSample;
            StSample: begin
                if (acc_ce != '0) begin
                    state_d = StServe;
                end else if (acc_done) begin
                    state_d = StFinish;
                end else begin
                    state_d = StStep;
                end
            end
            StServe: begin
                if (!sel_valid) begin
                    state_d = StStep;
                end else if (sel_we) begin
                    state_d = StWaitWr;
                end else if (!sel_hit) begin
                    state_d = StWaitRd;
                end
            end
            StWaitRd: begin
                if (rd_ready) begin
                    state_d = StServe;
                end else if (timed_out) begin
                    state_d = StFinish;
                end
            end
            StWaitWr: begin
                if (wr_ready) begin
                    state_d = StServe;
                end else if (timed_out) begin
                    state_d = StFinish;
                end
            end
            StFinish: if (!start) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        acc_step  = (state_q == StStep);
        acc_start = (state_q != StIdle) && (state_q != StFinish);
    end

    // Datapath next-state.
    always_comb begin
        pend_d         = pend_q;
        pend_we_d      = pend_we_q;
        pend_addr_d    = pend_addr_q;
        pend_wdata_d   = pend_wdata_q;
        acc_q_d        = acc_q_q;
        cur_d          = cur_q;
        timer_d        = timer_q;
        rd_req_d       = 1'b0;
        wr_req_d       = 1'b0;
        rd_addr_d      = rd_addr_q;
        wr_addr_d      = wr_addr_q;
        rd_size_d      = rd_size_q;
        wr_size_d      = wr_size_q;
        wr_data_d      = wr_data_q;
        done_d         = done_q;
        error_d        = error_q;
        access_count_d = access_count_q;
        cycle_count_d  = cycle_count_q;
        cache_clear    = 1'b0;
        cache_fill     = 1'b0;
        cache_inv      = 1'b0;

        unique case (state_q)
            StStep: cycle_count_d = cycle_count_q + 64'd1;
            StSample: begin
                pend_d       = acc_ce;
                pend_we_d    = acc_we;
                pend_addr_d  = acc_addr;
                pend_wdata_d = acc_d;
                if ((acc_ce == '0) && acc_done) begin
                    done_d = 1'b1;
                end
            end
            StServe: begin
                if (sel_valid) begin
                    pend_d[sel_idx] = 1'b0;
                    cur_d           = sel_idx;
                    timer_d         = '0;
                    if (sel_we) begin
                        wr_req_d       = 1'b1;
                        wr_addr_d      = byte_addr(write_base, 64'(sel_addr));
                        wr_data_d      = sel_wdata;
                        wr_size_d      = xfer_size;
                        access_count_d = access_count_q + 64'd1;
                        cache_inv      = 1'b1;
                    end else if (sel_hit) begin
                        acc_q_d[sel_idx*DATA_WID +: DATA_WID] = cache_data[sel_idx];
                    end else begin
                        rd_req_d       = 1'b1;
                        rd_addr_d      = byte_addr(read_base, 64'(sel_addr));
                        rd_size_d      = xfer_size;
                        access_count_d = access_count_q + 64'd1;
                    end
                end
            end
            StWaitRd: begin
                if (rd_ready) begin
                    acc_q_d[cur_q*DATA_WID +: DATA_WID] = rd_data;
                    cache_fill = 1'b1;
                end else if (timed_out) begin
                    error_d = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            StWaitWr: begin
                if (!wr_ready) begin
                    if (timed_out) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        timer_d = timer_q + 32'd1;
                    end
                end
            end
            StFinish: begin
                if (!start) begin
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    cache_clear = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q         <= '0;
            pend_we_q      <= '0;
            pend_addr_q    <= '0;
            pend_wdata_q   <= '0;
            acc_q_q        <= '0;
            cur_q          <= '0;
            timer_q        <= '0;
            rd_req_q       <= 1'b0;
            wr_req_q       <= 1'b0;
            rd_addr_q      <= '0;
            wr_addr_q      <= '0;
            rd_size_q      <= '0;
            wr_size_q      <= '0;
            wr_data_q      <= '0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            access_count_q <= '0;
            cycle_count_q  <= '0;
        end else begin
            pend_q         <= pend_d;
            pend_we_q      <= pend_we_d;
            pend_addr_q    <= pend_addr_d;
            pend_wdata_q   <= pend_wdata_d;
            acc_q_q        <= acc_q_d;
            cur_q          <= cur_d;
            timer_q        <= timer_d;
            rd_req_q       <= rd_req_d;
            wr_req_q       <= wr_req_d;
            rd_addr_q      <= rd_addr_d;
            wr_addr_q      <= wr_addr_d;
            rd_size_q      <= rd_size_d;
            wr_size_q      <= wr_size_d;
            wr_data_q      <= wr_data_d;
            done_q         <= done_d;
            error_q        <= error_d;
            access_count_q <= access_count_d;
            cycle_count_q  <= cycle_count_d;
        end
    end

    assign acc_q        = acc_q_q;
    assign rd_req       = rd_req_q;
    assign wr_req       = wr_req_q;
    assign rd_addr      = rd_addr_q;
    assign wr_addr      = wr_addr_q;
    assign rd_size      = rd_size_q;
    assign wr_size      = wr_size_q;
    assign wr_data      = wr_data_q;
    assign done         = done_q;
    assign error        = error_q;
    assign access_count = access_count_q;
    assign cycle_count  = cycle_count_q;

endmodule

// File: doc/stream_port_bridge.md
STREAM_PORT_BRIDGE -- requirements
Module: stream_port_bridge

Interface
REQ-001 Parameters (name, default, meaning): ADDR_WID, 16, accelerator word-address width; DATA_WID, 32, data width; NUM_PORTS, 2, accelerator memory ports (1..4); HIT_CACHE, 1, per-port last-read bypass enable; TIMEOUT, 1024, max cycles waiting on host ready.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; begin run.
- read_base, write_base  in  64  byte base addresses.
- xfer_size  in  64  value copied to rd_size / wr_size.
- acc_addr  in  NUM_PORTS*ADDR_WID  packed port addresses.
- acc_ce, acc_we  in  NUM_PORTS  per-port enables.
- acc_d  in  NUM_PORTS*DATA_WID  write data.
- acc_q  out  NUM_PORTS*DATA_WID  read data.
- acc_step  out  1  one-cycle accelerator clock enable.
- acc_start  out  1  accelerator ap_start.
- acc_done  in  1  accelerator ap_done.
- rd_req, wr_req  out  1  one-cycle request pulses.
- rd_addr, wr_addr  out  64  byte address.
- rd_size, wr_size  out  64  transfer size.
- wr_data  out  DATA_WID  write data.
- rd_ready, wr_ready  in  1  host completion; rd_data is valid with rd_ready.
- rd_data  in  DATA_WID  read return.
- done, error  out  1  sticky completion / timeout flags.
- access_count, cycle_count  out  64  external accesses issued; acc_step pulses issued.

Function
REQ-004 FSM states SHALL be IDLE, STEP, SAMPLE, SERVE, WAIT_RD, WAIT_WR, FINISH.
REQ-005 IDLE -> STEP when start=1; acc_start SHALL be 1 from leaving IDLE until entering FINISH.
REQ-006 STEP SHALL drive acc_step=1 for exactly one cycle, increment cycle_count, and go to SAMPLE.
REQ-007 SAMPLE SHALL latch acc_ce, acc_we, acc_addr and acc_d of all ports into a pending set; if no ce is set: -> FINISH when acc_done=1, else -> STEP.
REQ-008 SERVE SHALL take the lowest-index pending port, clear its pending bit, and return to STEP once the pending set is empty.
REQ-009 A pending write SHALL pulse wr_req with wr_addr=write_base+(addr<<2), wr_data=d and wr_size=xfer_size, then enter WAIT_WR.
REQ-010 A pending read SHALL pulse rd_req with rd_addr=read_base+(addr<<2) and rd_size=xfer_size, then enter WAIT_RD, unless the read is a cache hit (REQ-012).
REQ-011 WAIT_RD / WAIT_WR SHALL return to SERVE on the cycle the matching ready is 1. In WAIT_RD, rd_data SHALL be captured into that port's acc_q slice.
REQ-012 With HIT_CACHE=1, each port SHALL hold {valid, addr, data} from its last external read.
- A read whose addr equals the valid entry is a hit: acc_q is updated in SERVE, no rd_req is issued, and access_count is not incremented.
- Any served write SHALL invalidate every port entry with an equal addr.
REQ-013 acc_q slices SHALL hold their value until the next read on that port.
REQ-014 access_count SHALL increment once per rd_req or wr_req pulse; all counters wrap modulo 2^64.
REQ-015 If a wait exceeds TIMEOUT cycles without ready, the block SHALL set error=1 and go to FINISH.
REQ-016 FINISH SHALL set done=1 and hold it, with acc_start=0 and no further requests; start=0 -> IDLE, clearing done, error and the cache entries.
REQ-017 When acc_done and pending accesses occur together in SAMPLE, all accesses SHALL be served before FINISH.
REQ-018 A ready arriving outside WAIT_RD / WAIT_WR SHALL be ignored.

Reset
REQ-019 Asserting reset (low) at any time SHALL force state IDLE, clear all outputs, counters, pending bits and cache entries to 0, and abandon any outstanding host transaction.

Structure
REQ-020 The FSM state encoding and default parameter constants SHALL live in a shared package stream_bridge_pkg.
REQ-021 The per-port hit cache SHALL be one sub-module, port_read_cache, instantiated NUM_PORTS times.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- NUM_PORTS=2, both ports read addr 5 and 9, read_base=0x1000 -> rd_addr 0x1014 then 0x1024 in order, two rd_req pulses, access_count=2.
- Port0 writes 0xDEADBEEF to addr 3, port1 reads addr 3 in the same step -> wr_req first (wr_addr=write_base+12), then rd_req.
- Port0 reads addr 7 twice in consecutive steps with HIT_CACHE=1 -> one rd_req, acc_q0 identical both times; after a write to addr 7, the next read issues rd_req.
- rd_ready held low for TIMEOUT+1 cycles -> error=1, done=1, no further requests.
- acc_done=1 with a pending write -> write completes, then done=1 with cycle_count equal to the acc_step pulses issued.
- reset driven low during WAIT_WR -> all outputs 0 immediately; after release, start=1 reruns from cycle_count=0.
